rib_bus_arbiter: RTL and testbench
==================================

# rib_bus_arbiter

Three-master arbiter and request multiplexer for the core's shared memory bus. It sits between the masters and the interconnect's single master port:

- m0: core data/execute port
- m1: core instruction-fetch port
- m2: UART debug loader

It grants one master per cycle, keeps the bus locked for a debug master burst, prevents fetch starvation with a saturating counter, and generates the pipeline hold flag for the core.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive denied fetch cycles before m1 is forced a grant (1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- m0_req_i / m1_req_i / m2_req_i  in  1 each  master requests
- m0_addr_i / m1_addr_i / m2_addr_i  in  ADDR_W each  master addresses
- m0_wdata_i / m1_wdata_i / m2_wdata_i  in  DATA_W each  master write data
- m0_we_i / m1_we_i / m2_we_i  in  1 each  write enables
- m0_gnt_o / m1_gnt_o / m2_gnt_o  out  1 each  grants, one-hot or zero
- m0_rdata_o / m1_rdata_o / m2_rdata_o  out  DATA_W each  read data
- bus_req_o  out  1  request to interconnect
- bus_addr_o  out  ADDR_W  muxed address
- bus_wdata_o  out  DATA_W  muxed write data
- bus_we_o  out  1  muxed write enable
- bus_rdata_i  in  DATA_W  interconnect read data
- hold_flag_o  out  1  stall request to core pipeline
- owner_o  out  2  registered owner of previous cycle: 0/1/2, 3 = none

## Operation
State registers:
- lock: m2 burst lock
- starve_cnt: 4-bit, saturating at STARVE_LIMIT
- owner_q

Grant selection is combinational on the current cycle. It is evaluated in this order, first match wins:
1. lock=1 and m2_req_i=1 -> m2.
2. starve_cnt==STARVE_LIMIT and m1_req_i=1 -> m1 (forced).
3. Fixed priority m2 > m0 > m1 among asserted requests.
4. No request -> no grant.

Lock:
- Set on any cycle m2 is granted.
- Cleared on the edge after a cycle with m2_req_i=0.
- While lock=1 and m2_req_i=1, the m0 and m1 requests are ignored. This also overrides starvation.

starve_cnt:
- m1_req_i=1 and m1 not granted -> +1, saturating at STARVE_LIMIT.
- m1 granted or m1_req_i=0 -> 0.

Multiplexing:
- bus_addr_o, bus_wdata_o and bus_we_o come from the granted master.
- With no grant, these outputs are all-zero and bus_req_o=0.
- bus_rdata_i is routed only to the granted master's rdata. All other rdata outputs are 0.

Other outputs:
- hold_flag_o = m1_req_i & ~m1_gnt_o, or any grant to m2. This freezes fetch and PC while the bus is taken.
- owner_q <= index of the granted master, or 3 if none.

During rst=1:
- All grants, bus_req_o and hold_flag_o are forced to 0, and all muxed outputs and rdata outputs are 0.
- Registers clear: lock=0, starve_cnt=0, owner_q=3.

## Timing
- Grant latency is 0 cycles: a request asserted in cycle N is granted in cycle N if it wins. Single-cycle RIB reads return in the same cycle.
- Lock, counter and owner_o update at the end of the cycle. owner_o lags the grant by 1 cycle.
- Reset values:
  - all *_gnt_o = 0, bus_req_o = 0, bus_we_o = 0, hold_flag_o = 0
  - all data/address outputs = 0
  - owner_o = 3
- Reset asserted mid-burst drops the m2 lock on that edge. After rst deasserts, fresh arbitration applies: m2 regains the bus only by priority.
- Simultaneous m0+m1+m2 requests with lock=0 and starve_cnt<LIMIT: m2 is granted and lock is set.
- Starvation boundary:
  - m1 is denied exactly STARVE_LIMIT consecutive cycles.
  - In the next cycle it is granted regardless of m0.
  - The counter returns to 0 and m0 wins again in the following cycle.
- Forced m1 grant and m2 with lock=0 in the same cycle: m1 wins. m2 wins next cycle.
- m2_req_i dropping for one cycle ends the burst. m0 may take the bus in that cycle.

## Test plan
- Reset: hold rst=1 for 3 cycles with all requests high -> all gnt=0, bus_req_o=0, hold_flag_o=0, owner_o=3. On the first cycle after release, m2_gnt_o=1.
- Priority: m0_req=m1_req=1, m0_addr=0x1000_0004, bus_rdata_i=0xDEAD_BEEF -> m0_gnt=1, bus_addr_o=0x1000_0004, m0_rdata_o=0xDEADBEEF, m1_rdata_o=0, hold_flag_o=1.
- Starvation, STARVE_LIMIT=8: m0_req and m1_req held high for 20 cycles -> m1 granted in cycles 9 and 18 only. starve_cnt sequence is 1..8, 0, 1..8, 0.
- Lock: m2 requests for cycles 0-5 while m0 is constantly high -> m2 granted in cycles 0-5 and m0 in cycle 6. owner_o=2 for cycles 1-6 and 0 in cycle 7.
- Lock override of starvation: m1 is at starve_cnt=8 when an m2 burst is already locked -> m1 is held off until m2_req drops, then granted in that cycle.
- Reset mid-burst: m2 is locked, rst pulses 1 cycle, then m0 and m2 both request -> m2 is re-granted by priority with lock re-set. With m0 alone requesting after reset, m0 is granted immediately.

Source files
------------

// File: rtl/rib_bus_arbiter_if.sv
// Bundle of master-side and interconnect-side signals for the three-master RIB arbiter.
// Debug outputs expose the lock state and the fetch starvation counter.
interface rib_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // A master holds req until it sees gnt; a transfer occurs in any cycle with req and gnt both high.
    logic              m0_req_i,   m1_req_i,   m2_req_i;
    logic [ADDR_W-1:0] m0_addr_i,  m1_addr_i,  m2_addr_i;
    logic [DATA_W-1:0] m0_wdata_i, m1_wdata_i, m2_wdata_i;
    logic              m0_we_i,    m1_we_i,    m2_we_i;
    logic              m0_gnt_o,   m1_gnt_o,   m2_gnt_o;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o, m2_rdata_o;
    logic              bus_req_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_we_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              hold_flag_o;
    logic [1:0]        owner_o;
    logic              dbg_lock_o;
    logic [3:0]        dbg_starve_cnt_o;

    modport slave (
        input  m0_req_i, m1_req_i, m2_req_i,
        input  m0_addr_i, m1_addr_i, m2_addr_i,
        input  m0_wdata_i, m1_wdata_i, m2_wdata_i,
        input  m0_we_i, m1_we_i, m2_we_i,
        output m0_gnt_o, m1_gnt_o, m2_gnt_o,
        output m0_rdata_o, m1_rdata_o, m2_rdata_o,
        output bus_req_o, bus_addr_o, bus_wdata_o, bus_we_o,
        input  bus_rdata_i,
        output hold_flag_o, owner_o, dbg_lock_o, dbg_starve_cnt_o
    );

    modport master (
        output m0_req_i, m1_req_i, m2_req_i,
        output m0_addr_i, m1_addr_i, m2_addr_i,
        output m0_wdata_i, m1_wdata_i, m2_wdata_i,
        output m0_we_i, m1_we_i, m2_we_i,
        input  m0_gnt_o, m1_gnt_o, m2_gnt_o,
        input  m0_rdata_o, m1_rdata_o, m2_rdata_o,
        input  bus_req_o, bus_addr_o, bus_wdata_o, bus_we_o,
        output bus_rdata_i,
        input  hold_flag_o, owner_o, dbg_lock_o, dbg_starve_cnt_o
    );
endinterface

// File: rtl/rib_bus_arbiter.sv
// Three-master RIB arbiter: m2 burst lock, m1 anti-starvation forcing, fixed priority m2 > m0 > m1.
// Grants are combinational; lock, starvation counter and owner register update on the clock edge.
module rib_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    rib_bus_arbiter_if.slave   bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

    lock_state_t       r_state, w_state_nxt;
    logic [3:0]        r_starve_cnt, w_starve_nxt;
    logic [1:0]        r_owner, w_owner_nxt;
    logic [2:0]        w_gnt;
    logic              w_force_m1;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;

    assign w_force_m1 = (r_starve_cnt == LIMIT) && bus.m1_req_i;

    // Lock beats forced fetch, which beats plain priority.
    always_comb begin
        w_gnt = 3'b000;
        if (rst)                                          w_gnt = 3'b000;
        else if ((r_state == ST_LOCKED) && bus.m2_req_i)  w_gnt = 3'b100;
        else if (w_force_m1)                              w_gnt = 3'b010;
        else if (bus.m2_req_i)                            w_gnt = 3'b100;
        else if (bus.m0_req_i)                            w_gnt = 3'b001;
        else if (bus.m1_req_i)                            w_gnt = 3'b010;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = 4'd0;
        w_owner_nxt  = 2'd3;
        if (w_gnt[2])
            w_state_nxt = ST_LOCKED;
        else if (!bus.m2_req_i)
            w_state_nxt = ST_OPEN;
        if (bus.m1_req_i && !w_gnt[1])
            w_starve_nxt = (r_starve_cnt >= LIMIT) ? LIMIT : r_starve_cnt + 4'd1;
        if (w_gnt[0])      w_owner_nxt = 2'd0;
        else if (w_gnt[1]) w_owner_nxt = 2'd1;
        else if (w_gnt[2]) w_owner_nxt = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_OPEN;
            r_starve_cnt <= 4'd0;
            r_owner      <= 2'd3;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        if (w_gnt[0]) begin
            w_addr = bus.m0_addr_i; w_wdata = bus.m0_wdata_i; w_we = bus.m0_we_i;
        end else if (w_gnt[1]) begin
            w_addr = bus.m1_addr_i; w_wdata = bus.m1_wdata_i; w_we = bus.m1_we_i;
        end else if (w_gnt[2]) begin
            w_addr = bus.m2_addr_i; w_wdata = bus.m2_wdata_i; w_we = bus.m2_we_i;
        end
    end

    assign bus.m0_gnt_o    = w_gnt[0];
    assign bus.m1_gnt_o    = w_gnt[1];
    assign bus.m2_gnt_o    = w_gnt[2];
    assign bus.bus_req_o   = |w_gnt;
    assign bus.bus_addr_o  = w_addr;
    assign bus.bus_wdata_o = w_wdata;
    assign bus.bus_we_o    = w_we;
    assign bus.m0_rdata_o  = w_gnt[0] ? bus.bus_rdata_i : '0;
    assign bus.m1_rdata_o  = w_gnt[1] ? bus.bus_rdata_i : '0;
    assign bus.m2_rdata_o  = w_gnt[2] ? bus.bus_rdata_i : '0;
    // Fetch and PC freeze while fetch is waiting or the debug loader owns the bus.
    assign bus.hold_flag_o = !rst && ((bus.m1_req_i && !w_gnt[1]) || w_gnt[2]);
    assign bus.owner_o          = r_owner;
    assign bus.dbg_lock_o       = (r_state == ST_LOCKED);
    assign bus.dbg_starve_cnt_o = r_starve_cnt;
endmodule

// File: tb/tb_rib_bus_arbiter.sv
// Directed bench for rib_bus_arbiter: single-cycle vector table plus multi-cycle
// sequences for reset, starvation, burst lock and their interactions.
module tb_rib_bus_arbiter;
  localparam logic [31:0] A0 = 32'h1000_0004, A1 = 32'h2000_0008, A2 = 32'h3000_000C;
  localparam logic [31:0] D0 = 32'hA000_00A0, D1 = 32'hB100_00B1, D2 = 32'hC200_00C2;
  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  rib_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  rib_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;      // {m2,m1,m0}
    logic [2:0]  we;
    logic [2:0]  exp_gnt;
    logic        exp_hold;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_we;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] we);
    bif.m0_req_i = req[0]; bif.m1_req_i = req[1]; bif.m2_req_i = req[2];
    bif.m0_we_i  = we[0];  bif.m1_we_i  = we[1];  bif.m2_we_i  = we[2];
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'b000, 3'b000);
    next_cycle();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gnt_vec();
    return {29'd0, bif.m2_gnt_o, bif.m1_gnt_o, bif.m0_gnt_o};
  endfunction

  initial begin
    bif.m0_addr_i = A0; bif.m1_addr_i = A1; bif.m2_addr_i = A2;
    bif.m0_wdata_i = D0; bif.m1_wdata_i = D1; bif.m2_wdata_i = D2;
    bif.bus_rdata_i = RD;
    drive(3'b000, 3'b000);

    //                req     we      gnt     hold  addr  wdata  we
    vecs[0] = '{3'b000, 3'b000, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0};
    vecs[1] = '{3'b001, 3'b001, 3'b001, 1'b0, A0,    D0,    1'b1};
    vecs[2] = '{3'b010, 3'b000, 3'b010, 1'b0, A1,    D1,    1'b0};
    vecs[3] = '{3'b100, 3'b100, 3'b100, 1'b1, A2,    D2,    1'b1};
    vecs[4] = '{3'b011, 3'b010, 3'b001, 1'b1, A0,    D0,    1'b0};
    vecs[5] = '{3'b111, 3'b011, 3'b100, 1'b1, A2,    D2,    1'b0};
    vecs[6] = '{3'b110, 3'b110, 3'b100, 1'b1, A2,    D2,    1'b1};
    vecs[7] = '{3'b101, 3'b001, 3'b100, 1'b1, A2,    D2,    1'b0};

    // Reset held 3 cycles with every master requesting.
    rst = 1'b1;
    drive(3'b111, 3'b111);
    for (int c = 0; c < 3; c++) begin
      to_sample();
      chk("rst_gnt",   gnt_vec(), 32'd0);
      chk("rst_busreq", {31'd0, bif.bus_req_o}, 32'd0);
      chk("rst_hold",  {31'd0, bif.hold_flag_o}, 32'd0);
      chk("rst_we",    {31'd0, bif.bus_we_o}, 32'd0);
      chk("rst_addr",  bif.bus_addr_o, 32'd0);
      chk("rst_rdata2", bif.m2_rdata_o, 32'd0);
      if (c > 0) chk("rst_owner", {30'd0, bif.owner_o}, 32'd3);
      next_cycle();
    end
    rst = 1'b0;
    to_sample();
    chk("post_rst_m2_gnt", gnt_vec(), 32'b100);
    chk("post_rst_owner", {30'd0, bif.owner_o}, 32'd3);
    next_cycle();

    // Single-cycle vectors from a clean state.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(vecs[i].req, vecs[i].we);
      to_sample();
      chk($sformatf("v%0d_gnt", i),   gnt_vec(), {29'd0, vecs[i].exp_gnt});
      chk($sformatf("v%0d_busreq", i), {31'd0, bif.bus_req_o}, {31'd0, |vecs[i].exp_gnt});
      chk($sformatf("v%0d_addr", i),  bif.bus_addr_o, vecs[i].exp_addr);
      chk($sformatf("v%0d_wdata", i), bif.bus_wdata_o, vecs[i].exp_wdata);
      chk($sformatf("v%0d_we", i),    {31'd0, bif.bus_we_o}, {31'd0, vecs[i].exp_we});
      chk($sformatf("v%0d_hold", i),  {31'd0, bif.hold_flag_o}, {31'd0, vecs[i].exp_hold});
      chk($sformatf("v%0d_rd0", i),   bif.m0_rdata_o, vecs[i].exp_gnt[0] ? RD : 32'd0);
      chk($sformatf("v%0d_rd1", i),   bif.m1_rdata_o, vecs[i].exp_gnt[1] ? RD : 32'd0);
      chk($sformatf("v%0d_rd2", i),   bif.m2_rdata_o, vecs[i].exp_gnt[2] ? RD : 32'd0);
      next_cycle();
    end

    // Starvation: m0+m1 for 20 cycles, m1 forced in cycles 9 and 18.
    do_reset();
    drive(3'b011, 3'b000);
    for (int c = 1; c <= 20; c++) begin
      logic exp_m1;
      logic [31:0] exp_cnt;
      exp_m1 = (c == 9) || (c == 18);
      exp_cnt = (c <= 8) ? 32'(c) : (c == 9) ? 32'd0 : (c <= 17) ? 32'(c - 9) : 32'(c - 18);
      to_sample();
      chk($sformatf("starve_c%0d_m1", c), {31'd0, bif.m1_gnt_o}, {31'd0, exp_m1});
      chk($sformatf("starve_c%0d_m0", c), {31'd0, bif.m0_gnt_o}, {31'd0, !exp_m1});
      chk($sformatf("starve_c%0d_hold", c), {31'd0, bif.hold_flag_o}, {31'd0, !exp_m1});
      next_cycle();
      chk($sformatf("starve_c%0d_cnt", c), {28'd0, bif.dbg_starve_cnt_o}, exp_cnt);
    end

    // Lock: m2 in cycles 0-5 with m0 always requesting.
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      drive({c <= 5, 1'b0, 1'b1}, 3'b000);
      to_sample();
      chk($sformatf("lock_c%0d_m2", c), {31'd0, bif.m2_gnt_o}, {31'd0, c <= 5});
      chk($sformatf("lock_c%0d_m0", c), {31'd0, bif.m0_gnt_o}, {31'd0, c >= 6});
      chk($sformatf("lock_c%0d_owner", c), {30'd0, bif.owner_o},
          (c == 0) ? 32'd3 : (c <= 6) ? 32'd2 : 32'd0);
      next_cycle();
    end

    // Lock overrides starvation: all request, m1 saturates at 8 while m2 holds the bus.
    do_reset();
    drive(3'b111, 3'b000);
    for (int c = 0; c <= 8; c++) begin
      to_sample();
      chk($sformatf("lovr_c%0d_gnt", c), gnt_vec(), 32'b100);
      next_cycle();
    end
    chk("lovr_cnt_sat", {28'd0, bif.dbg_starve_cnt_o}, 32'd8);
    drive(3'b011, 3'b000);
    to_sample();
    chk("lovr_lock_still", {31'd0, bif.dbg_lock_o}, 32'd1);
    chk("lovr_m1_forced", gnt_vec(), 32'b010);
    next_cycle();
    to_sample();
    chk("lovr_m0_after", gnt_vec(), 32'b001);
    chk("lovr_unlocked", {31'd0, bif.dbg_lock_o}, 32'd0);
    next_cycle();

    // Forced m1 beats unlocked m2; m2 wins the next cycle.
    do_reset();
    drive(3'b011, 3'b000);
    for (int c = 0; c < 8; c++) next_cycle();
    drive(3'b111, 3'b000);
    to_sample();
    chk("force_vs_m2_gnt", gnt_vec(), 32'b010);
    chk("force_vs_m2_lock", {31'd0, bif.dbg_lock_o}, 32'd0);
    next_cycle();
    to_sample();
    chk("force_vs_m2_next", gnt_vec(), 32'b100);
    next_cycle();

    // One-cycle m2 gap ends the burst; m0 takes the bus in that cycle.
    do_reset();
    drive(3'b101, 3'b000);
    next_cycle();
    drive(3'b001, 3'b000);
    to_sample();
    chk("gap_m0_gnt", gnt_vec(), 32'b001);
    next_cycle();
    drive(3'b101, 3'b000);
    to_sample();
    chk("gap_m2_regrant", gnt_vec(), 32'b100);
    next_cycle();

    // Reset mid-burst, then m0+m2: m2 regains by priority and relocks.
    do_reset();
    drive(3'b100, 3'b000);
    next_cycle();
    chk("mid_locked", {31'd0, bif.dbg_lock_o}, 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("mid_lock_dropped", {31'd0, bif.dbg_lock_o}, 32'd0);
    drive(3'b101, 3'b000);
    to_sample();
    chk("mid_m2_regrant", gnt_vec(), 32'b100);
    next_cycle();
    chk("mid_relock", {31'd0, bif.dbg_lock_o}, 32'd1);

    // Reset mid-burst, then m0 alone: granted immediately.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(3'b001, 3'b000);
    to_sample();
    chk("mid_m0_gnt", gnt_vec(), 32'b001);
    chk("mid_m0_owner", {30'd0, bif.owner_o}, 32'd3);
    next_cycle();
    chk("mid_m0_owner_next", {30'd0, bif.owner_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
